// File: rtl/dbus_arbiter_if.sv
// Bundle of the data-bus controller signals: two requester ports, the shared
// slave bus, the per-slave strobe/ack/data pairs and the core stall flag.
// The master modport is the controller's own view. The slave modport is the
// environment's view, covering the requesters and the slaves.
interface dbus_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  // requester 0 (core data port)
  logic              m0_req;
  logic [ADDR_W-1:0] m0_adr;
  logic [DATA_W-1:0] m0_wdat;
  logic [3:0]        m0_sel;
  logic              m0_we;
  logic [DATA_W-1:0] m0_rdat;
  logic              m0_ack;
  logic              m0_err;

  // requester 1 (loader/debug port)
  logic              m1_req;
  logic [ADDR_W-1:0] m1_adr;
  logic [DATA_W-1:0] m1_wdat;
  logic [3:0]        m1_sel;
  logic              m1_we;
  logic [DATA_W-1:0] m1_rdat;
  logic              m1_ack;
  logic              m1_err;

  // shared slave bus
  logic              s_cyc;
  logic [ADDR_W-1:0] s_adr;
  logic [DATA_W-1:0] s_wdat;
  logic [3:0]        s_sel;
  logic              s_we;

  // data RAM
  logic              ram_stb;
  logic [DATA_W-1:0] ram_rdat;
  logic              ram_ack;

  // RSA accelerator register window
  logic              rsa_stb;
  logic [DATA_W-1:0] rsa_rdat;
  logic              rsa_ack;

  // core stall
  logic              busy;

  modport master (
    input  m0_req, m0_adr, m0_wdat, m0_sel, m0_we,
    output m0_rdat, m0_ack, m0_err,
    input  m1_req, m1_adr, m1_wdat, m1_sel, m1_we,
    output m1_rdat, m1_ack, m1_err,
    output s_cyc, s_adr, s_wdat, s_sel, s_we,
    output ram_stb, input ram_rdat, ram_ack,
    output rsa_stb, input rsa_rdat, rsa_ack,
    output busy
  );

  modport slave (
    output m0_req, m0_adr, m0_wdat, m0_sel, m0_we,
    input  m0_rdat, m0_ack, m0_err,
    output m1_req, m1_adr, m1_wdat, m1_sel, m1_we,
    input  m1_rdat, m1_ack, m1_err,
    input  s_cyc, s_adr, s_wdat, s_sel, s_we,
    input  ram_stb, output ram_rdat, ram_ack,
    input  rsa_stb, output rsa_rdat, rsa_ack,
    input  busy
  );

endinterface

// File: rtl/dbus_arbiter.sv
// Data-bus controller. It arbitrates two requesters round-robin, decodes the
// address to the data RAM or the RSA register window, and runs one
// Wishbone-style cycle per request with an ack timeout. It returns registered
// read data, a one-cycle ack or err pulse, and a busy flag for the core stall.
module dbus_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter logic [3:0]  RSA_REGION = 4'h4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic           clk,
  input  logic           rst,
  dbus_arbiter_if.master bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_grant_q, last_grant_d;
  logic              tgt_rsa_q, tgt_rsa_d;
  logic [7:0]        tmo_cnt_q, tmo_cnt_d;

  logic              s_cyc_q, s_cyc_d;
  logic [ADDR_W-1:0] s_adr_q, s_adr_d;
  logic [DATA_W-1:0] s_wdat_q, s_wdat_d;
  logic [3:0]        s_sel_q, s_sel_d;
  logic              s_we_q, s_we_d;
  logic              ram_stb_q, ram_stb_d;
  logic              rsa_stb_q, rsa_stb_d;

  logic [DATA_W-1:0] m0_rdat_q, m0_rdat_d;
  logic [DATA_W-1:0] m1_rdat_q, m1_rdat_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m0_err_q, m0_err_d;
  logic              m1_ack_q, m1_ack_d;
  logic              m1_err_q, m1_err_d;
  logic              busy_q, busy_d;

  logic              arb_valid;
  logic              arb_pick;
  logic [ADDR_W-1:0] pick_adr;
  logic [DATA_W-1:0] pick_wdat;
  logic [3:0]        pick_sel;
  logic              pick_we;

  logic              slv_ack;
  logic [DATA_W-1:0] slv_rdat;

  logic              fin;
  logic              fin_err;
  logic              fin_who;
  logic [DATA_W-1:0] fin_data;

  // Round-robin choice between the requesters and the fields of the winner.
  always_comb begin
    arb_valid = bus.m0_req | bus.m1_req;
    if (bus.m0_req && bus.m1_req) begin
      arb_pick = ~last_grant_q;
    end else begin
      arb_pick = bus.m1_req;
    end
    pick_adr  = arb_pick ? bus.m1_adr  : bus.m0_adr;
    pick_wdat = arb_pick ? bus.m1_wdat : bus.m0_wdat;
    pick_sel  = arb_pick ? bus.m1_sel  : bus.m0_sel;
    pick_we   = arb_pick ? bus.m1_we   : bus.m0_we;
  end

  // Only the decoded slave's ack and data are considered.
  always_comb begin
    slv_ack  = tgt_rsa_q ? bus.rsa_ack  : bus.ram_ack;
    slv_rdat = tgt_rsa_q ? bus.rsa_rdat : bus.ram_rdat;
  end

  // Bus cycle sequencing: IDLE grants, BUS waits for ack or timeout, RESP pulses.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    tgt_rsa_d    = tgt_rsa_q;
    tmo_cnt_d    = tmo_cnt_q;
    s_cyc_d      = s_cyc_q;
    s_adr_d      = s_adr_q;
    s_wdat_d     = s_wdat_q;
    s_sel_d      = s_sel_q;
    s_we_d       = s_we_q;
    ram_stb_d    = ram_stb_q;
    rsa_stb_d    = rsa_stb_q;
    fin          = 1'b0;
    fin_err      = 1'b0;
    fin_who      = gnt_q;
    fin_data     = '0;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          gnt_d        = arb_pick;
          last_grant_d = arb_pick;
          s_adr_d      = pick_adr;
          s_wdat_d     = pick_wdat;
          s_sel_d      = pick_sel;
          s_we_d       = pick_we;
          tgt_rsa_d    = (pick_adr[19:16] == RSA_REGION);
          tmo_cnt_d    = '0;
          if (pick_sel == 4'b0000) begin
            // Empty byte mask: reject without touching the bus.
            state_d = ST_RESP;
            fin     = 1'b1;
            fin_err = 1'b1;
            fin_who = arb_pick;
          end else begin
            state_d   = ST_BUS;
            s_cyc_d   = 1'b1;
            ram_stb_d = (pick_adr[19:16] != RSA_REGION);
            rsa_stb_d = (pick_adr[19:16] == RSA_REGION);
          end
        end
      end

      ST_BUS: begin
        tmo_cnt_d = tmo_cnt_q + 8'd1;
        // The ack check comes first, so an ack on the last allowed cycle still completes.
        if (slv_ack) begin
          state_d   = ST_RESP;
          s_cyc_d   = 1'b0;
          ram_stb_d = 1'b0;
          rsa_stb_d = 1'b0;
          fin       = 1'b1;
          fin_data  = s_we_q ? '0 : slv_rdat;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = ST_RESP;
          s_cyc_d   = 1'b0;
          ram_stb_d = 1'b0;
          rsa_stb_d = 1'b0;
          fin       = 1'b1;
          fin_err   = 1'b1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        s_cyc_d   = 1'b0;
        ram_stb_d = 1'b0;
        rsa_stb_d = 1'b0;
      end
    endcase
  end

  // Route the completion pulse and data to the granted requester only.
  always_comb begin
    m0_rdat_d = m0_rdat_q;
    m1_rdat_d = m1_rdat_q;
    m0_ack_d  = 1'b0;
    m0_err_d  = 1'b0;
    m1_ack_d  = 1'b0;
    m1_err_d  = 1'b0;
    if (fin) begin
      if (fin_who) begin
        m1_rdat_d = fin_data;
        m1_ack_d  = ~fin_err;
        m1_err_d  = fin_err;
      end else begin
        m0_rdat_d = fin_data;
        m0_ack_d  = ~fin_err;
        m0_err_d  = fin_err;
      end
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any cycle in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      tgt_rsa_q    <= 1'b0;
      tmo_cnt_q    <= '0;
      s_cyc_q      <= 1'b0;
      s_adr_q      <= '0;
      s_wdat_q     <= '0;
      s_sel_q      <= '0;
      s_we_q       <= 1'b0;
      ram_stb_q    <= 1'b0;
      rsa_stb_q    <= 1'b0;
      m0_rdat_q    <= '0;
      m1_rdat_q    <= '0;
      m0_ack_q     <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      tgt_rsa_q    <= tgt_rsa_d;
      tmo_cnt_q    <= tmo_cnt_d;
      s_cyc_q      <= s_cyc_d;
      s_adr_q      <= s_adr_d;
      s_wdat_q     <= s_wdat_d;
      s_sel_q      <= s_sel_d;
      s_we_q       <= s_we_d;
      ram_stb_q    <= ram_stb_d;
      rsa_stb_q    <= rsa_stb_d;
      m0_rdat_q    <= m0_rdat_d;
      m1_rdat_q    <= m1_rdat_d;
      m0_ack_q     <= m0_ack_d;
      m0_err_q     <= m0_err_d;
      m1_ack_q     <= m1_ack_d;
      m1_err_q     <= m1_err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.s_cyc   = s_cyc_q;
  assign bus.s_adr   = s_adr_q;
  assign bus.s_wdat  = s_wdat_q;
  assign bus.s_sel   = s_sel_q;
  assign bus.s_we    = s_we_q;
  assign bus.ram_stb = ram_stb_q;
  assign bus.rsa_stb = rsa_stb_q;
  assign bus.m0_rdat = m0_rdat_q;
  assign bus.m1_rdat = m1_rdat_q;
  assign bus.m0_ack  = m0_ack_q;
  assign bus.m0_err  = m0_err_q;
  assign bus.m1_ack  = m1_ack_q;
  assign bus.m1_err  = m1_err_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Randomized bench for dbus_arbiter. It uses a transaction-level reference
// model that works from timestamps. Each grant fixes its stb window, its ack
// or timeout cycle and its response cycle.
module tb_dbus_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;
  localparam int NCYC = 4000;
  localparam int PH1  = 300;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dbus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dbus_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .RSA_REGION(4'h4),
    .TIMEOUT   (TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_bad = 0;
  int t;

  // requesters
  bit          pend   [2];
  logic [31:0] r_adr  [2];
  logic [31:0] r_wdat [2];
  logic [3:0]  r_sel  [2];
  logic        r_we   [2];

  // reference model
  bit          act;
  int          owner, t_gnt, resp_t, win_lo, win_hi, ack_t, last_g;
  bit          is_rsa, is_err;
  logic [31:0] x_adr, x_wdat, resp_data;
  logic [3:0]  x_sel;
  logic        x_we;
  logic [31:0] exp_rdat [2];
  bit          rst_prev;
  logic [31:0] ram_rd, rsa_rd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  task automatic new_fields(input int i);
    r_adr[i]  = $urandom;
    if ($urandom_range(0, 1) == 1) r_adr[i][19:16] = 4'h4;
    else if (r_adr[i][19:16] == 4'h4) r_adr[i][19:16] = 4'h0;
    r_wdat[i] = $urandom;
    r_sel[i]  = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    r_we[i]   = 1'($urandom_range(0, 1));
  endtask

  task automatic do_grant();
    int g, k, d;
    if (pend[0] && pend[1]) g = (last_g == 0) ? 1 : 0;
    else g = pend[1] ? 1 : 0;
    last_g    = g;
    owner     = g;
    t_gnt     = t;
    act       = 1'b1;
    x_adr     = r_adr[g];
    x_wdat    = r_wdat[g];
    x_sel     = r_sel[g];
    x_we      = r_we[g];
    is_rsa    = (x_adr[19:16] == 4'h4);
    resp_data = '0;
    win_lo    = t + 1;
    if (x_sel == 4'h0) begin
      is_err = 1'b1;
      win_hi = t;
      ack_t  = -1;
      resp_t = t + 1;
    end else begin
      k = $urandom_range(0, 19);
      if (k < 11)      d = $urandom_range(0, 3);
      else if (k < 14) d = TMO - 1;
      else if (k < 15) d = TMO - 2;
      else             d = TMO + 2;
      if (d < TMO) begin
        is_err = 1'b0;
        ack_t  = t + 1 + d;
        win_hi = ack_t;
        resp_t = ack_t + 1;
      end else begin
        is_err = 1'b1;
        ack_t  = -1;
        win_hi = t + TMO;
        resp_t = t + TMO + 1;
      end
    end
  endtask

  initial begin
    bit in_win, done_now, rst_now, exp_busy;
    pend = '{0, 0};
    for (int i = 0; i < 2; i++) new_fields(i);
    act = 1'b0;
    last_g = 1;
    exp_rdat = '{32'h0, 32'h0};
    rst_prev = 1'b1;
    owner = 0; t_gnt = 0; resp_t = -1; win_lo = 1; win_hi = 0; ack_t = -1;
    is_rsa = 0; is_err = 0; x_adr = '0; x_wdat = '0; x_sel = '0; x_we = 0; resp_data = '0;
    bus.m0_req = 0; bus.m0_adr = '0; bus.m0_wdat = '0; bus.m0_sel = '0; bus.m0_we = 0;
    bus.m1_req = 0; bus.m1_adr = '0; bus.m1_wdat = '0; bus.m1_sel = '0; bus.m1_we = 0;
    bus.ram_rdat = '0; bus.ram_ack = 0; bus.rsa_rdat = '0; bus.rsa_ack = 0;
    @(posedge clk);
    #1;
    for (t = 0; t < NCYC; t++) begin
      // ---- drive inputs for cycle t
      in_win  = act && (t >= win_lo) && (t <= win_hi);
      rst_now = (t < 3) ||
                (t >= PH1 && in_win && $urandom_range(0, 40) == 0) ||
                (t >= PH1 && $urandom_range(0, 400) == 0);
      rst = ~rst_now;
      for (int i = 0; i < 2; i++) begin
        if (!pend[i]) begin
          if (t < PH1 || $urandom_range(0, 2) == 0) begin
            pend[i] = 1'b1;
            new_fields(i);
          end
        end else if (!(act && owner == i) && $urandom_range(0, 3) == 0) begin
          new_fields(i);
        end
      end
      bus.m0_req = pend[0]; bus.m0_adr = r_adr[0]; bus.m0_wdat = r_wdat[0];
      bus.m0_sel = r_sel[0]; bus.m0_we = r_we[0];
      bus.m1_req = pend[1]; bus.m1_adr = r_adr[1]; bus.m1_wdat = r_wdat[1];
      bus.m1_sel = r_sel[1]; bus.m1_we = r_we[1];
      ram_rd = $urandom;
      rsa_rd = $urandom;
      bus.ram_rdat = ram_rd;
      bus.rsa_rdat = rsa_rd;
      bus.ram_ack = act && (ack_t == t) && !is_rsa;
      bus.rsa_ack = act && (ack_t == t) && is_rsa;
      if (in_win && $urandom_range(0, 3) == 0) begin
        if (is_rsa) bus.ram_ack = 1'b1;
        else        bus.rsa_ack = 1'b1;
      end
      if (rst_prev) begin
        bus.ram_ack = 1'b1;
        bus.rsa_ack = 1'b1;
      end

      // ---- check outputs of cycle t
      @(negedge clk);
      if (act && t == resp_t) exp_rdat[owner] = resp_data;
      exp_busy = act && (t > t_gnt) && (t <= resp_t);
      chk("s_cyc",   64'(bus.s_cyc),   64'(in_win));
      chk("ram_stb", 64'(bus.ram_stb), 64'(in_win && !is_rsa));
      chk("rsa_stb", 64'(bus.rsa_stb), 64'(in_win && is_rsa));
      chk("busy",    64'(bus.busy),    64'(exp_busy));
      if (in_win) begin
        chk("s_adr",  64'(bus.s_adr),  64'(x_adr));
        chk("s_wdat", 64'(bus.s_wdat), 64'(x_wdat));
        chk("s_sel",  64'(bus.s_sel),  64'(x_sel));
        chk("s_we",   64'(bus.s_we),   64'(x_we));
      end
      if (rst_prev) begin
        chk("rst_s_adr",  64'(bus.s_adr),  64'h0);
        chk("rst_s_wdat", 64'(bus.s_wdat), 64'h0);
        chk("rst_s_sel",  64'(bus.s_sel),  64'h0);
        chk("rst_s_we",   64'(bus.s_we),   64'h0);
      end
      chk("m0_ack",  64'(bus.m0_ack),  64'(act && t == resp_t && owner == 0 && !is_err));
      chk("m0_err",  64'(bus.m0_err),  64'(act && t == resp_t && owner == 0 && is_err));
      chk("m1_ack",  64'(bus.m1_ack),  64'(act && t == resp_t && owner == 1 && !is_err));
      chk("m1_err",  64'(bus.m1_err),  64'(act && t == resp_t && owner == 1 && is_err));
      chk("m0_rdat", 64'(bus.m0_rdat), 64'(exp_rdat[0]));
      chk("m1_rdat", 64'(bus.m1_rdat), 64'(exp_rdat[1]));

      // ---- advance the model with the inputs of cycle t
      done_now = 1'b0;
      if (act && t == ack_t && !x_we) resp_data = is_rsa ? rsa_rd : ram_rd;
      if (act && t == resp_t) begin
        pend[owner] = 1'b0;
        act = 1'b0;
        done_now = 1'b1;
      end
      if (!rst) begin
        act = 1'b0;
        last_g = 1;
        exp_rdat = '{32'h0, 32'h0};
      end else if (!act && !done_now && (pend[0] || pend[1])) begin
        do_grant();
      end
      rst_prev = ~rst;

      @(posedge clk);
      #1;
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
